// File: rtl/display_pkg.sv
// Shared types and helpers for the seven-segment scanner.
package display_pkg;

   // Active-low pattern with every segment dark.
   localparam logic [6:0] SEG_OFF = 7'h7F;

   typedef enum logic {
      S_BLANK,
      S_SHOW
   } scan_state_t;

   // Active-low digit select: only bit idx is low; bits at or above n stay high.
   function automatic logic [7:0] digit_onecold(input logic [2:0] idx, input int unsigned n);
      logic [7:0] v;
      v = 8'hFF;
      if (32'(idx) < n) begin
         v[idx] = 1'b0;
      end
      return v;
   endfunction

endpackage

// File: rtl/scan_slot_timer.sv
// Slot timer: free-running counter over one digit slot (blank + show).
// The counter holds the slot position of the cycle that begins at the next
// clock edge, so the strobes let the scanner register its outputs in step.
module scan_slot_timer #(
   parameter int unsigned TICK_DIV     = 50000,
   parameter int unsigned BLANK_CYCLES = 500
) (
   input  logic clk,
   input  logic rst,
   output logic blank_end,
   output logic slot_end
);

   localparam int unsigned CNT_W = $clog2(TICK_DIV);

   logic [CNT_W-1:0] r_cnt;

   // Count 0..TICK_DIV-1 and wrap.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (r_cnt == CNT_W'(TICK_DIV - 1)) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // blank_end: the next cycle is the first show cycle of the slot.
   // slot_end:  the next cycle is the last cycle of the slot.
   assign blank_end = (r_cnt == CNT_W'(BLANK_CYCLES));
   assign slot_end  = (r_cnt == CNT_W'(TICK_DIV - 1));

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed common-anode seven-segment driver with a double-buffered
// frame input and a blanking interval ahead of every digit.
module seven_segment_scanner
   import display_pkg::*;
#(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned TICK_DIV     = 50000,
   parameter int unsigned BLANK_CYCLES = 500
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_DIGITS*7-1:0] frame_data,
   input  logic                    frame_valid,
   output logic                    frame_ready,
   output logic [6:0]              seg_n,
   output logic [NUM_DIGITS-1:0]   digit_sel_n,
   output logic                    frame_done
);

   localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   scan_state_t             r_state;
   logic [IDX_W-1:0]        r_idx;
   logic                    r_last;
   logic [6:0]              r_seg;
   logic [NUM_DIGITS-1:0]   r_sel;
   logic                    r_done;
   logic [NUM_DIGITS*7-1:0] r_active;
   logic [NUM_DIGITS*7-1:0] r_pend;
   logic                    r_pend_empty;

   logic       w_blank_end;
   logic       w_slot_end;
   logic       w_idx_last;
   logic       w_wrap;
   logic       w_hs;
   logic [7:0] w_onecold;
   logic [6:0] w_active_seg;
   logic       w_unused_onecold;

   scan_slot_timer #(
      .TICK_DIV    (TICK_DIV),
      .BLANK_CYCLES(BLANK_CYCLES)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .blank_end(w_blank_end),
      .slot_end (w_slot_end)
   );

   assign w_idx_last       = (r_idx == IDX_W'(NUM_DIGITS - 1));
   // Wrap cycle: last show cycle of the final digit, i.e. the current cycle.
   assign w_wrap           = (r_state == S_SHOW) && r_last && w_idx_last;
   assign w_hs             = frame_valid && r_pend_empty;
   assign w_onecold        = digit_onecold(3'(r_idx), NUM_DIGITS);
   assign w_unused_onecold = ^w_onecold;
   assign w_active_seg     = r_active[32'(r_idx) * 7 +: 7];

   // Slot FSM: outputs are registered for the cycle entered at each edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_BLANK;
         r_idx   <= '0;
         r_last  <= 1'b0;
         r_seg   <= SEG_OFF;
         r_sel   <= '1;
         r_done  <= 1'b0;
      end else begin
         unique case (r_state)
            S_BLANK: begin
               r_done <= 1'b0;
               if (w_blank_end) begin
                  r_state <= S_SHOW;
                  r_sel   <= w_onecold[NUM_DIGITS-1:0];
                  r_seg   <= w_active_seg;
                  // A one-cycle show phase is also the last cycle of the slot.
                  r_last  <= w_slot_end;
                  r_done  <= w_slot_end && w_idx_last;
               end
            end
            S_SHOW: begin
               if (w_slot_end) begin
                  r_last <= 1'b1;
                  r_done <= w_idx_last;
               end else if (r_last) begin
                  r_last  <= 1'b0;
                  r_state <= S_BLANK;
                  r_seg   <= SEG_OFF;
                  r_sel   <= '1;
                  r_done  <= 1'b0;
                  r_idx   <= w_idx_last ? '0 : r_idx + 1'b1;
               end
            end
            default: begin
               r_state <= S_BLANK;
            end
         endcase
      end
   end

   // Frame buffers: pending takes handshakes, active swaps at the wrap.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_active     <= {NUM_DIGITS{SEG_OFF}};
         r_pend       <= {NUM_DIGITS{SEG_OFF}};
         r_pend_empty <= 1'b1;
      end else if (w_wrap) begin
         if (!r_pend_empty) begin
            r_active     <= r_pend;
            r_pend_empty <= 1'b1;
         end else if (w_hs) begin
            // Bypass: a frame arriving on the wrap goes straight to active.
            r_active <= frame_data;
         end
      end else if (w_hs) begin
         r_pend       <= frame_data;
         r_pend_empty <= 1'b0;
      end
   end

   assign frame_ready = r_pend_empty;
   assign seg_n       = r_seg;
   assign digit_sel_n = r_sel;
   assign frame_done  = r_done;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench for seven_segment_scanner with NUM_DIGITS=4, TICK_DIV=8, BLANK_CYCLES=2.
module tb_seven_segment_scanner;

   logic        clk;
   logic        rst;
   logic [27:0] frame_data;
   logic        frame_valid;
   logic        frame_ready;
   logic [6:0]  seg_n;
   logic [3:0]  digit_sel_n;
   logic        frame_done;

   int n_tests;
   int n_fail;
   int cyc;

   localparam logic [27:0] OFF = {4{7'h7F}};
   localparam logic [27:0] F1  = {7'h77, 7'h7B, 7'h7D, 7'h7E};
   localparam logic [27:0] F2  = {7'h12, 7'h24, 7'h30, 7'h79};
   localparam logic [27:0] F3  = {7'h40, 7'h19, 7'h02, 7'h78};

   seven_segment_scanner #(
      .NUM_DIGITS  (4),
      .TICK_DIV    (8),
      .BLANK_CYCLES(2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .frame_data (frame_data),
      .frame_valid(frame_valid),
      .frame_ready(frame_ready),
      .seg_n      (seg_n),
      .digit_sel_n(digit_sel_n),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected segment drive in cycle c when frame fr is active.
   function automatic logic [6:0] exp_seg(input int c, input logic [27:0] fr);
      int s;
      int d;
      s = c % 8;
      d = (c / 8) % 4;
      if (s < 2) return 7'h7F;
      return fr[7*d +: 7];
   endfunction

   function automatic logic [3:0] exp_sel(input int c);
      if ((c % 8) < 2) return 4'hF;
      return 4'hF & ~(4'b0001 << ((c / 8) % 4));
   endfunction

   // Advance one clock and sample 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc = cyc + 1;
   endtask

   task automatic apply_reset();
      rst         = 1'b0;
      frame_valid = 1'b0;
      frame_data  = OFF;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      cyc = -1;
   endtask

   task automatic test_reset();
      rst         = 1'b0;
      frame_valid = 1'b0;
      frame_data  = F1;
      cyc         = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         frame_valid = ~frame_valid;
         n_tests++;
         if (seg_n !== 7'h7F) begin
            n_fail++;
            $display("FAIL reset_seg i=%0d got=%h exp=7f", i, seg_n);
         end
         n_tests++;
         if (digit_sel_n !== 4'hF) begin
            n_fail++;
            $display("FAIL reset_sel i=%0d got=%h exp=f", i, digit_sel_n);
         end
         n_tests++;
         if (frame_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready i=%0d got=%b exp=1", i, frame_ready);
         end
         n_tests++;
         if (frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_done i=%0d got=%b exp=0", i, frame_done);
         end
      end
      frame_valid = 1'b0;
   endtask

   task automatic test_scan_idle();
      apply_reset();
      for (int i = 0; i < 64; i++) begin
         tick();
         n_tests++;
         if (seg_n !== 7'h7F || digit_sel_n !== exp_sel(cyc)) begin
            n_fail++;
            $display("FAIL idle_scan cyc=%0d got=%h/%h exp=7f/%h", cyc, seg_n, digit_sel_n,
                     exp_sel(cyc));
         end
         n_tests++;
         if (frame_done !== ((cyc % 32) == 31)) begin
            n_fail++;
            $display("FAIL idle_done cyc=%0d got=%b", cyc, frame_done);
         end
      end
   endtask

   task automatic test_frame_load();
      logic [27:0] fr;
      logic        exp_rdy;
      apply_reset();
      for (int i = 0; i < 96; i++) begin
         tick();
         fr      = (cyc < 32) ? OFF : (cyc < 64) ? F1 : F2;
         exp_rdy = !((cyc >= 11 && cyc <= 31) || (cyc >= 33 && cyc <= 63));
         n_tests++;
         if (seg_n !== exp_seg(cyc, fr) || digit_sel_n !== exp_sel(cyc)) begin
            n_fail++;
            $display("FAIL load_seg cyc=%0d got=%h/%h exp=%h/%h", cyc, seg_n, digit_sel_n,
                     exp_seg(cyc, fr), exp_sel(cyc));
         end
         n_tests++;
         if (frame_ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL load_ready cyc=%0d got=%b exp=%b", cyc, frame_ready, exp_rdy);
         end
         n_tests++;
         if (frame_done !== ((cyc % 32) == 31)) begin
            n_fail++;
            $display("FAIL load_done cyc=%0d got=%b", cyc, frame_done);
         end
         if (cyc == 10) begin
            frame_data  = F1;
            frame_valid = 1'b1;
         end else if (cyc == 11) begin
            frame_valid = 1'b0;
         end else if (cyc == 12) begin
            frame_data  = F2;
            frame_valid = 1'b1;
         end else if (cyc == 33) begin
            frame_valid = 1'b0;
         end
      end
   endtask

   task automatic test_bypass();
      logic [27:0] fr;
      apply_reset();
      for (int i = 0; i < 64; i++) begin
         tick();
         fr = (cyc < 32) ? OFF : F3;
         n_tests++;
         if (seg_n !== exp_seg(cyc, fr) || digit_sel_n !== exp_sel(cyc)) begin
            n_fail++;
            $display("FAIL bypass_seg cyc=%0d got=%h/%h exp=%h/%h", cyc, seg_n, digit_sel_n,
                     exp_seg(cyc, fr), exp_sel(cyc));
         end
         n_tests++;
         if (frame_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bypass_ready cyc=%0d got=%b exp=1", cyc, frame_ready);
         end
         if (cyc == 31) begin
            frame_data  = F3;
            frame_valid = 1'b1;
         end else if (cyc == 32) begin
            frame_valid = 1'b0;
         end
      end
   endtask

   task automatic test_async_reset();
      apply_reset();
      for (int i = 0; i < 53; i++) begin
         tick();
         if (cyc == 3) begin
            frame_data  = F1;
            frame_valid = 1'b1;
         end else if (cyc == 4) begin
            frame_data  = F2;
         end else if (cyc == 33) begin
            frame_valid = 1'b0;
         end
      end
      // Cycle 52: digit 2 showing from F1, F2 sitting in pending.
      n_tests++;
      if (seg_n !== 7'h7B || digit_sel_n !== 4'hB) begin
         n_fail++;
         $display("FAIL pre_reset_show got=%h/%h exp=7b/b", seg_n, digit_sel_n);
      end
      n_tests++;
      if (frame_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL pre_reset_ready got=%b exp=0", frame_ready);
      end
      #2 rst = 1'b0;
      #1;
      n_tests++;
      if (seg_n !== 7'h7F || digit_sel_n !== 4'hF || frame_ready !== 1'b1
          || frame_done !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset got=%h/%h/%b/%b exp=7f/f/1/0", seg_n, digit_sel_n,
                  frame_ready, frame_done);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      cyc = -1;
      for (int i = 0; i < 64; i++) begin
         tick();
         n_tests++;
         if (seg_n !== 7'h7F || digit_sel_n !== exp_sel(cyc) || frame_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset cyc=%0d got=%h/%h/%b exp=7f/%h/1", cyc, seg_n,
                     digit_sel_n, frame_ready, exp_sel(cyc));
         end
      end
   endtask

   initial begin
      n_tests     = 0;
      n_fail      = 0;
      cyc         = 0;
      rst         = 1'b0;
      frame_valid = 1'b0;
      frame_data  = OFF;
      test_reset();
      test_scan_idle();
      test_frame_load();
      test_bypass();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
